dds_dac_generator: RTL and testbench

//  Multi-channel DDS waveform generator driving an LTC2624-style quad SPI DAC.
//  Per-channel phase accumulators and waveform modes; frames are serialised channel by channel.

---
 rtl/dds_dac_pkg.sv | 28 ++
 rtl/dds_dac_generator_spi_frame_tx.sv | 76 +++++++
 rtl/dds_dac_generator.sv | 147 ++++++++++++++
 tb/tb_dds_dac_generator.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_dac_pkg.sv
// Shared encodings for the DDS generator and its SPI frame serialiser.
// Mode codes, DAC command, frame width and FSM states.
package dds_dac_pkg;

  localparam logic [1:0] MODE_SAW    = 2'd0;
  localparam logic [1:0] MODE_SQUARE = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  localparam logic [3:0] DAC_CMD_WRUPD = 4'b0011;
  localparam int         FRAME_W       = 32;

  typedef enum logic [2:0] {
    S_CLR   = 3'd0,
    S_IDLE  = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  function automatic logic [FRAME_W-1:0] dac_frame(
    input logic [3:0]  ch,
    input logic [11:0] data
  );
    return {8'h00, DAC_CMD_WRUPD, ch, data, 4'h0};
  endfunction

endpackage

// File: rtl/dds_dac_generator_spi_frame_tx.sv
// Serialises one 32-bit DAC frame MSB first; sck idle low, data changes on falling sck.
// done is high during the last sck-high cycle, just before cs returns high.
module spi_frame_tx
  import dds_dac_pkg::*;
#(
  parameter int SCK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               sck,
  output logic               mosi,
  output logic               cs,
  output logic               done
);

  localparam int HALVES = 2 * FRAME_W;
  localparam int HW     = $clog2(HALVES);
  localparam int DW     = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

  logic               active;
  logic               ld;
  logic [HW-1:0]      half;
  logic [DW-1:0]      div;
  logic [FRAME_W-1:0] shreg;
  logic               half_end;

  assign half_end = active && !ld && (div == DW'(SCK_DIV - 1));
  assign done     = half_end && (half == HW'(HALVES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      ld     <= 1'b0;
      half   <= '0;
      div    <= '0;
      shreg  <= '0;
      sck    <= 1'b0;
      mosi   <= 1'b0;
      cs     <= 1'b1;
    end else if (start && !active) begin
      active <= 1'b1;
      ld     <= 1'b1;
      half   <= '0;
      div    <= '0;
      shreg  <= frame << 1;
      sck    <= 1'b0;
      mosi   <= frame[FRAME_W-1];
      cs     <= 1'b0;
    end else if (active) begin
      if (ld) begin
        ld <= 1'b0;
      end else if (half_end) begin
        div <= '0;
        if (done) begin
          active <= 1'b0;
          sck    <= 1'b0;
          mosi   <= 1'b0;
          cs     <= 1'b1;
        end else begin
          half <= half + HW'(1);
          sck  <= ~sck;
          // a falling edge presents the next bit
          if (sck) begin
            mosi  <= shreg[FRAME_W-1];
            shreg <= shreg << 1;
          end
        end
      end else begin
        div <= div + DW'(1);
      end
    end
  end

endmodule

// File: rtl/dds_dac_generator.sv
// Multi-channel DDS generator feeding an LTC2624-style quad SPI DAC.
// Define DDS_AMPL_EN to add the per-channel ampl port (4-bit amplitude scaling).
module dds_dac_generator
  import dds_dac_pkg::*;
#(
  parameter int DIV      = 50000,
  parameter int SIZE     = 12,
  parameter int CHANNELS = 2,
  parameter int PHASE_W  = 16,
  parameter int SCK_DIV  = 2,
  parameter int CS_GAP   = 4,
  parameter int CLR_CYC  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [CHANNELS*PHASE_W-1:0]   freq_word,
  input  logic [CHANNELS*2-1:0]         mode,
`ifdef DDS_AMPL_EN
  input  logic [CHANNELS*4-1:0]         ampl,
`endif
  output logic                          spi_mosi,
  output logic                          spi_sck,
  output logic                          dac_cs,
  output logic                          dac_clr,
  output logic                          busy,
  output logic                          overrun
);

  localparam int TW  = $clog2(DIV);
  localparam int CW  = $clog2(CLR_CYC + 1);
  localparam int GW  = $clog2(CS_GAP);
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_t             state, state_nx;
  logic [TW-1:0]      tick_cnt;
  logic [CW-1:0]      clr_cnt;
  logic [GW-1:0]      gap_cnt;
  logic [CHW-1:0]     ch;
  logic [PHASE_W-1:0] phase [CHANNELS];
  logic [SIZE-1:0]    held  [CHANNELS];
  logic               tick;
  logic               tx_start;
  logic               tx_done;
  logic [1:0]         ch_mode;
  logic [SIZE-1:0]    p;
  logic [SIZE-1:0]    wave;
  logic [SIZE-1:0]    sample;
  logic [11:0]        data;
  logic [FRAME_W-1:0] frame;
`ifdef DDS_AMPL_EN
  logic [4:0]         gain;
  logic [SIZE+3:0]    prod;
`endif

  assign tick = (state != S_CLR) && (tick_cnt == TW'(DIV - 1));
  assign busy = (state == S_LOAD) || (state == S_SHIFT) || (state == S_GAP);

  always_comb begin
    ch_mode = mode[ch*2 +: 2];
    p       = phase[ch][PHASE_W-1 -: SIZE];
    wave    = p;
    unique case (1'b1)
      (ch_mode == MODE_SQUARE): wave = {SIZE{p[SIZE-1]}};
      (ch_mode == MODE_TRI):    wave = p[SIZE-1] ? (~p) << 1 : p << 1;
      default:                  wave = p;
    endcase
`ifdef DDS_AMPL_EN
    gain   = {1'b0, ampl[ch*4 +: 4]} + 5'd1;
    prod   = (SIZE+4)'(wave) * (SIZE+4)'(gain);
    sample = SIZE'(prod >> 4);
`else
    sample = wave;
`endif
    // hold replays whatever went out last, scaled or not
    if (ch_mode == MODE_HOLD) sample = held[ch];
    data  = 12'(sample) << (12 - SIZE);
    frame = dac_frame(4'(ch), data);
  end

  always_comb begin
    state_nx = state;
    tx_start = 1'b0;
    unique case (state)
      S_CLR:   if (clr_cnt == CW'(CLR_CYC)) state_nx = S_IDLE;
      S_IDLE:  if (tick && enable) state_nx = S_LOAD;
      S_LOAD: begin
        tx_start = 1'b1;
        state_nx = S_SHIFT;
      end
      S_SHIFT: if (tx_done) state_nx = S_GAP;
      S_GAP: begin
        // cs stays high through GAP plus the following LOAD cycle
        if (gap_cnt == GW'(CS_GAP - 2))
          state_nx = (ch == CHW'(CHANNELS - 1)) ? S_IDLE : S_LOAD;
      end
      default: state_nx = S_CLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CLR;
      tick_cnt <= '0;
      clr_cnt  <= '0;
      gap_cnt  <= '0;
      ch       <= '0;
      dac_clr  <= 1'b0;
      overrun  <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) begin
        phase[n] <= '0;
        held[n]  <= '0;
      end
    end else begin
      state <= state_nx;
      if (state == S_CLR) begin
        if (clr_cnt == CW'(CLR_CYC)) dac_clr <= 1'b1;
        else clr_cnt <= clr_cnt + CW'(1);
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      end
      if (tick && busy) overrun <= 1'b1;
      if (state == S_IDLE && tick && enable) begin
        ch <= '0;
        for (int n = 0; n < CHANNELS; n++)
          phase[n] <= phase[n] + freq_word[n*PHASE_W +: PHASE_W];
      end
      if (state == S_LOAD) held[ch] <= sample;
      gap_cnt <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;
      if (state == S_GAP && state_nx == S_LOAD) ch <= ch + CHW'(1);
    end
  end

  spi_frame_tx #(
    .SCK_DIV (SCK_DIV)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .start (tx_start),
    .frame (frame),
    .sck   (spi_sck),
    .mosi  (spi_mosi),
    .cs    (dac_cs),
    .done  (tx_done)
  );

endmodule

// File: tb/tb_dds_dac_generator.sv
// Bench for dds_dac_generator: SPI frame monitor, vector table and DDS reference model.
// Instance a runs at DIV=400, instance b at DIV=100 to force overruns.
module tb_dds_dac_generator;

  localparam int CH    = 2;
  localparam int PW    = 16;
  localparam int DIV_A = 400;
  localparam int DIV_B = 100;
  localparam int FLEN  = 1 + 64 * 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1;
  logic en_a = 1'b0, en_b = 1'b0;
  logic [CH*PW-1:0] fw_a = '0, fw_b = '0;
  logic [CH*2-1:0]  md_a = '0, md_b = '0;
`ifdef DDS_AMPL_EN
  logic [CH*4-1:0]  am_a = '1, am_b = '1;
`endif
  logic [1:0] mosi, sck, cs, clr, bsy, ovr;

  dds_dac_generator #(
    .DIV(DIV_A), .SIZE(12), .CHANNELS(CH), .PHASE_W(PW),
    .SCK_DIV(2), .CS_GAP(4), .CLR_CYC(16)
  ) dut_a (
    .clk(clk), .rst(rst_a), .enable(en_a),
    .freq_word(fw_a), .mode(md_a),
`ifdef DDS_AMPL_EN
    .ampl(am_a),
`endif
    .spi_mosi(mosi[0]), .spi_sck(sck[0]), .dac_cs(cs[0]),
    .dac_clr(clr[0]), .busy(bsy[0]), .overrun(ovr[0])
  );

  dds_dac_generator #(
    .DIV(DIV_B), .SIZE(12), .CHANNELS(CH), .PHASE_W(PW),
    .SCK_DIV(2), .CS_GAP(4), .CLR_CYC(16)
  ) dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b),
    .freq_word(fw_b), .mode(md_b),
`ifdef DDS_AMPL_EN
    .ampl(am_b),
`endif
    .spi_mosi(mosi[1]), .spi_sck(sck[1]), .dac_cs(cs[1]),
    .dac_clr(clr[1]), .busy(bsy[1]), .overrun(ovr[1])
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // SPI monitor: shift on rising sck while cs low, emit frame on cs rise
  logic [31:0] sr [2];
  int          bc [2];
  int          lc [2];
  logic [1:0]  psck = 2'b00;
  logic [1:0]  pcs  = 2'b11;
  logic [31:0] qa [$];
  logic [31:0] qb [$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if ((i == 0) ? rst_a : rst_b) begin
        bc[i] = 0;
        lc[i] = 0;
      end else if (!cs[i]) begin
        lc[i]++;
        if (sck[i] && !psck[i]) begin
          sr[i] = {sr[i][30:0], mosi[i]};
          bc[i]++;
        end
      end else if (!pcs[i]) begin
        check($sformatf("frame_bits%0d", i), bc[i], 32);
        check($sformatf("frame_len%0d", i), lc[i], FLEN);
        if (i == 0) qa.push_back(sr[i]);
        else qb.push_back(sr[i]);
        bc[i] = 0;
        lc[i] = 0;
      end
      psck[i] = sck[i];
      pcs[i]  = cs[i];
    end
  end

  task automatic get_frame(input int which, output logic [31:0] f);
    int t;
    t = 0;
    while (((which == 0) ? qa.size() : qb.size()) == 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) f = 'x;
    else if (which == 0) f = qa.pop_front();
    else f = qb.pop_front();
  endtask

  task automatic wait_idle(input int which);
    int t;
    t = 0;
    while (bsy[which] && t < 1000) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    qa.delete();
    rst_a = 1'b0;
  endtask

  // reference model: phases and held samples from the arithmetic definition
  logic [15:0] mph   [CH];
  logic [11:0] mheld [CH];

  function automatic logic [11:0] ref_sample(input logic [1:0] m,
    input logic [15:0] ph, input logic [11:0] last, input logic [3:0] a);
    int p, s;
    p = int'(ph) / 16;
    if (m == 2'd3) return last;
    if (m == 2'd0) s = p;
    else if (m == 2'd1) s = (p >= 2048) ? 4095 : 0;
    else s = (p >= 2048) ? ((4095 - p) * 2) % 4096 : (p * 2) % 4096;
    s = s * (int'(a) + 1) / 16;
    return 12'(s);
  endfunction

  task automatic model_reset();
    for (int n = 0; n < CH; n++) begin
      mph[n]   = '0;
      mheld[n] = '0;
    end
  endtask

  task automatic sweep_a(input string nm);
    logic [31:0] f, e;
    logic [11:0] s;
    logic [3:0]  a;
    for (int n = 0; n < CH; n++) mph[n] = mph[n] + fw_a[n*PW +: PW];
    for (int n = 0; n < CH; n++) begin
      a = 4'd15;
`ifdef DDS_AMPL_EN
      a = am_a[n*4 +: 4];
`endif
      s = ref_sample(md_a[n*2 +: 2], mph[n], mheld[n], a);
      mheld[n] = s;
      e = 32'h0030_0000 + (n << 16) + (32'(s) << 4);
      get_frame(0, f);
      check($sformatf("%s_ch%0d", nm, n), f, e);
    end
    wait_idle(0);
  endtask

  typedef struct {
    logic [1:0]       m0, m1;
    logic [15:0]      f0, f1;
    logic [3:0][11:0] e0, e1;
  } vec_t;

  vec_t vt [4];

  initial begin : main
    logic [31:0] f;
    int low, t;
    logic seen;

    vt[0] = '{2'd0, 2'd0, 16'h1000, 16'h2000,
              {12'h400, 12'h300, 12'h200, 12'h100},
              {12'h800, 12'h600, 12'h400, 12'h200}};
    vt[1] = '{2'd1, 2'd2, 16'h8000, 16'h4000,
              {12'h000, 12'hFFF, 12'h000, 12'hFFF},
              {12'h000, 12'h7FE, 12'hFFE, 12'h800}};
    vt[2] = '{2'd3, 2'd3, 16'h1234, 16'h4321,
              {12'h000, 12'h000, 12'h000, 12'h000},
              {12'h000, 12'h000, 12'h000, 12'h000}};
    vt[3] = '{2'd0, 2'd1, 16'hF000, 16'h7FFF,
              {12'hC00, 12'hD00, 12'hE00, 12'hF00},
              {12'hFFF, 12'h000, 12'hFFF, 12'h000}};

    // reset values and clear pulse
    repeat (3) @(negedge clk);
    check("rst_cs", cs[0], 1);
    check("rst_sck", sck[0], 0);
    check("rst_mosi", mosi[0], 0);
    check("rst_clr", clr[0], 0);
    check("rst_busy", bsy[0], 0);
    check("rst_ovr", ovr[0], 0);
    rst_a = 1'b0;
    en_a  = 1'b1;
    low = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (clr[0]) break;
      low++;
    end
    check("clr_low_cycles", low, 16);
    seen = 1'b0;
    for (int k = 0; k < 350; k++) begin
      @(negedge clk);
      if (bsy[0] || !cs[0]) seen = 1'b1;
    end
    check("no_frame_before_tick", {31'd0, seen}, 0);

    // vector table, fresh reset per row
    for (int r = 0; r < 4; r++) begin
      reset_a();
      md_a = {vt[r].m1, vt[r].m0};
      fw_a = {vt[r].f1, vt[r].f0};
      for (int k = 0; k < 4; k++) begin
        get_frame(0, f);
        check($sformatf("tbl%0d_ch0_s%0d", r, k), f,
              32'h0030_0000 | (32'(vt[r].e0[k]) << 4));
        get_frame(0, f);
        check($sformatf("tbl%0d_ch1_s%0d", r, k), f,
              32'h0031_0000 | (32'(vt[r].e1[k]) << 4));
      end
      wait_idle(0);
    end

    // randomised sweeps against the model, with an enable-off stretch
    reset_a();
    model_reset();
    for (int s = 0; s < 12; s++) begin
      fw_a = {16'($urandom), 16'($urandom)};
      md_a = 4'($urandom_range(0, 15));
`ifdef DDS_AMPL_EN
      am_a = 8'($urandom);
`endif
      if (s == 6) begin
        en_a = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3 * DIV_A; k++) begin
          @(negedge clk);
          if (bsy[0]) seen = 1'b1;
        end
        check("disabled_no_sweep", {31'd0, seen}, 0);
        check("disabled_no_frame", qa.size(), 0);
        en_a = 1'b1;
      end
      sweep_a($sformatf("rnd%0d", s));
    end

    // overrun: ticks every 100 cycles, sweep ~267 cycles
    @(negedge clk);
    fw_b  = {16'h0800, 16'h1000};
    md_b  = '0;
    en_b  = 1'b1;
    rst_b = 1'b0;
    @(negedge clk);
    check("ovr_after_reset", ovr[1], 0);
    t = 0;
    while (!bsy[1] && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("ovr_first_sweep", bsy[1], 1);
    repeat (50) @(negedge clk);
    check("ovr_before_drop", ovr[1], 0);
    repeat (60) @(negedge clk);
    check("ovr_after_drop", ovr[1], 1);
    for (int k = 1; k <= 3; k++) begin
      get_frame(1, f);
      check($sformatf("ovr_ch0_s%0d", k), f,
            32'h0030_0000 | (32'(k * 12'h100) << 4));
      get_frame(1, f);
      check($sformatf("ovr_ch1_s%0d", k), f,
            32'h0031_0000 | (32'(k * 12'h080) << 4));
    end
    check("ovr_sticky", ovr[1], 1);

    // reset in the middle of a frame
    reset_a();
    model_reset();
    fw_a = {16'h0300, 16'h0500};
    md_a = '0;
    t = 0;
    while (!(bc[0] == 17 && !cs[0]) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("midrst_reached", bc[0], 17);
    qa.delete();
    rst_a = 1'b1;
    @(negedge clk);
    check("midrst_cs", cs[0], 1);
    check("midrst_sck", sck[0], 0);
    check("midrst_mosi", mosi[0], 0);
    check("midrst_clr", clr[0], 0);
    check("midrst_busy", bsy[0], 0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_no_partial", qa.size(), 0);
    sweep_a("post_rst");

`ifdef DDS_AMPL_EN
    reset_a();
    fw_a = {16'h8000, 16'h8000};
    md_a = '0;
    am_a = {4'd15, 4'd7};
    get_frame(0, f);
    check("ampl7", f, 32'h0030_4000);
    get_frame(0, f);
    check("ampl15", f, 32'h0031_8000);
    wait_idle(0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
